// File: rtl/sgr_pkg.sv
// sgr_pkg: shared command/state/attribute types for sgr_attribute_engine; SGR_EXT_EFFECTS_EN adds italic/strike/conceal/dim
package sgr_pkg;
    localparam int CH_BITS = 3;
    localparam int CW = 3 * CH_BITS;
    typedef enum logic [2:0] {
        CMD_NONE, CMD_INIT_PN, CMD_EMIT_PN, CMD_SGR, CMD_SGR0, CMD_SAVE, CMD_RESTORE
    } sgr_cmd_t;
    typedef enum logic [3:0] {
        S_START, S_FG, S_BG, S_FG_IDX, S_BG_IDX,
        S_FG_R, S_FG_G, S_FG_B, S_BG_R, S_BG_G, S_BG_B
    } sgr_state_t;
    typedef struct packed {
        logic underline;
        logic blink;
        logic negative;
        logic bright;
`ifdef SGR_EXT_EFFECTS_EN
        logic italic;
        logic strike;
        logic conceal;
        logic dim;
`endif
    } sgr_effect_t;
    typedef struct packed {
        logic [CW-1:0] fg;
        logic [CW-1:0] bg;
        sgr_effect_t   effect;
    } sgr_graphics_t;
    localparam logic [7:0] LVL_NORM8 = 8'hB0;
    localparam logic [CH_BITS-1:0] LVL_NORM = LVL_NORM8[7-:CH_BITS];
    localparam logic [CW-1:0] DEFAULT_FG = {3{LVL_NORM}};
    localparam logic [CW-1:0] DEFAULT_BG = '0;
    localparam sgr_graphics_t GFX_DEFAULT = '{fg: DEFAULT_FG, bg: DEFAULT_BG, effect: '0};
    function automatic logic [CW-1:0] ansi_color(input logic [2:0] idx, input logic bright);
        logic [CH_BITS-1:0] l;
        l = bright ? {CH_BITS{1'b1}} : LVL_NORM;
        return {l & {CH_BITS{idx[0]}}, l & {CH_BITS{idx[1]}}, l & {CH_BITS{idx[2]}}};
    endfunction
endpackage

// File: rtl/color256_to_rgb.sv
// color256_to_rgb: xterm 256-colour code to packed {R,G,B} word, each channel truncated to CH_BITS MSBs
module color256_to_rgb #(
    parameter int CH_BITS = 3
) (
    input  logic [7:0]           code_i,
    output logic [3*CH_BITS-1:0] rgb_o
);
    localparam logic [7:0] NORM8 = 8'hB0;
    localparam logic [CH_BITS-1:0] NORM = NORM8[7-:CH_BITS];
    function automatic logic [CH_BITS-1:0] cube(input logic [7:0] v);
        logic [7:0] l;
        l = (v == 8'd0) ? 8'd0 : 8'd55 + 8'd40 * v;
        return l[7-:CH_BITS];
    endfunction
    logic [7:0] c;
    logic [7:0] grey;
    logic [CH_BITS-1:0] lvl;
    // Select among the ANSI, 6x6x6 cube and grey-ramp regions of the palette
    always_comb begin
        c = code_i - 8'd16;
        grey = 8'd8 + 8'd10 * (code_i - 8'd232);
        lvl = code_i[3] ? {CH_BITS{1'b1}} : NORM;
        rgb_o = code_i < 8'd16 ? {lvl & {CH_BITS{code_i[0]}}, lvl & {CH_BITS{code_i[1]}}, lvl & {CH_BITS{code_i[2]}}}
              : code_i < 8'd232 ? {cube(c / 8'd36), cube((c / 8'd6) % 8'd6), cube(c % 8'd6)}
              : {3{grey[7-:CH_BITS]}};
    end
endmodule

// File: rtl/sgr_attribute_engine.sv
// sgr_attribute_engine: SGR attribute builder with atomic commit and save/restore stack; SGR_EXT_EFFECTS_EN enables extra effects
module sgr_attribute_engine
    import sgr_pkg::*;
#(
    parameter int STACK_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cmd_valid,
    input  sgr_cmd_t                           cmd_type,
    input  logic [7:0]                         pn,
    output logic                               cmd_ready,
    output sgr_graphics_t                      graphics,
    output logic                               graphics_valid,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count
);
    localparam int PW = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    localparam int CNTW = $clog2(STACK_DEPTH + 1);
    localparam int RH = CW - 1;
    localparam int GH = 2 * CH_BITS - 1;
    localparam int BH = CH_BITS - 1;
    sgr_graphics_t gfx_q, gfx_d, work_q, work_d, app_w, pop_g;
    sgr_graphics_t stack_q [STACK_DEPTH];
    sgr_state_t state_q, state_d, app_s;
    logic pend_q, pend_d, valid_q, valid_d, accept;
    logic [PW-1:0] ptr_q, ptr_nxt, ptr_prv;
    logic [CNTW-1:0] cnt_q;
    logic [CW-1:0] c256;

    color256_to_rgb #(.CH_BITS(CH_BITS)) u_c256 (.code_i(pn), .rgb_o(c256));

    assign accept = cmd_valid & ~pend_q;
    assign ptr_nxt = ptr_q == PW'(STACK_DEPTH - 1) ? '0 : ptr_q + 1'b1;
    assign ptr_prv = ptr_q == '0 ? PW'(STACK_DEPTH - 1) : ptr_q - 1'b1;
    assign pop_g = cnt_q != '0 ? stack_q[ptr_prv] : GFX_DEFAULT;
    assign cmd_ready = ~pend_q;
    assign graphics = gfx_q;
    assign graphics_valid = valid_q;
    assign stack_count = cnt_q;

    // Effect of one numeric parameter on the working copy given the parser state
    always_comb begin
        app_w = work_q;
        app_s = S_START;
        case (state_q)
            S_START: case (pn) inside
                8'd0:  app_w = GFX_DEFAULT;
                8'd1:  app_w.effect.bright = 1'b1;
                8'd22: begin
                    app_w.effect.bright = 1'b0;
`ifdef SGR_EXT_EFFECTS_EN
                    app_w.effect.dim = 1'b0;
`endif
                end
                8'd4:  app_w.effect.underline = 1'b1;
                8'd24: app_w.effect.underline = 1'b0;
                8'd5:  app_w.effect.blink = 1'b1;
                8'd25: app_w.effect.blink = 1'b0;
                8'd7:  app_w.effect.negative = 1'b1;
                8'd27: app_w.effect.negative = 1'b0;
`ifdef SGR_EXT_EFFECTS_EN
                8'd2:  app_w.effect.dim = 1'b1;
                8'd3:  app_w.effect.italic = 1'b1;
                8'd23: app_w.effect.italic = 1'b0;
                8'd9:  app_w.effect.strike = 1'b1;
                8'd29: app_w.effect.strike = 1'b0;
                8'd8:  app_w.effect.conceal = 1'b1;
                8'd28: app_w.effect.conceal = 1'b0;
`endif
                [8'd30:8'd36]:   app_w.fg = ansi_color(3'(pn - 8'd30), 1'b0);
                [8'd40:8'd46]:   app_w.bg = ansi_color(3'(pn - 8'd40), 1'b0);
                [8'd90:8'd97]:   app_w.fg = ansi_color(3'(pn - 8'd90), 1'b1);
                [8'd100:8'd107]: app_w.bg = ansi_color(3'(pn - 8'd100), 1'b1);
                8'd37, 8'd39: app_w.fg = DEFAULT_FG;
                8'd47: app_w.bg = DEFAULT_FG;
                8'd49: app_w.bg = DEFAULT_BG;
                8'd38: app_s = S_FG;
                8'd48: app_s = S_BG;
                default: ;
            endcase
            S_FG: app_s = pn == 8'd5 ? S_FG_IDX : pn == 8'd2 ? S_FG_R : S_START;
            S_BG: app_s = pn == 8'd5 ? S_BG_IDX : pn == 8'd2 ? S_BG_R : S_START;
            S_FG_IDX: app_w.fg = c256;
            S_BG_IDX: app_w.bg = c256;
            S_FG_R: begin app_w.fg[RH-:CH_BITS] = pn[7-:CH_BITS]; app_s = S_FG_G; end
            S_FG_G: begin app_w.fg[GH-:CH_BITS] = pn[7-:CH_BITS]; app_s = S_FG_B; end
            S_FG_B: app_w.fg[BH-:CH_BITS] = pn[7-:CH_BITS];
            S_BG_R: begin app_w.bg[RH-:CH_BITS] = pn[7-:CH_BITS]; app_s = S_BG_G; end
            S_BG_G: begin app_w.bg[GH-:CH_BITS] = pn[7-:CH_BITS]; app_s = S_BG_B; end
            S_BG_B: app_w.bg[BH-:CH_BITS] = pn[7-:CH_BITS];
            default: ;
        endcase
    end

    // Command dispatch; a pending commit blocks acceptance for exactly one cycle
    always_comb begin
        gfx_d = pend_q ? work_q : gfx_q;
        work_d = work_q;
        state_d = state_q;
        pend_d = 1'b0;
        valid_d = pend_q;
        if (accept) begin
            case (cmd_type)
                CMD_INIT_PN: begin work_d = gfx_q; state_d = S_START; end
                CMD_EMIT_PN: begin work_d = app_w; state_d = app_s; end
                CMD_SGR:     begin work_d = app_w; state_d = S_START; pend_d = 1'b1; end
                CMD_SGR0:    begin work_d = GFX_DEFAULT; pend_d = 1'b1; end
                CMD_RESTORE: begin gfx_d = pop_g; work_d = pop_g; valid_d = 1'b1; end
                default: ;
            endcase
        end
    end

    // Architectural state and stack bookkeeping, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gfx_q <= GFX_DEFAULT;
            work_q <= GFX_DEFAULT;
            state_q <= S_START;
            pend_q <= 1'b0;
            valid_q <= 1'b0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            gfx_q <= gfx_d;
            work_q <= work_d;
            state_q <= state_d;
            pend_q <= pend_d;
            valid_q <= valid_d;
            if (accept && cmd_type == CMD_SAVE) begin
                ptr_q <= ptr_nxt;
                cnt_q <= cnt_q == CNTW'(STACK_DEPTH) ? cnt_q : cnt_q + 1'b1;
            end else if (accept && cmd_type == CMD_RESTORE && cnt_q != '0) begin
                ptr_q <= ptr_prv;
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Stack entries are only read while counted as occupied, so they need no reset
    always_ff @(posedge clk) begin
        if (accept && cmd_type == CMD_SAVE) stack_q[ptr_q] <= gfx_q;
    end
endmodule
